// File: rtl/move_input_ctrl_if.sv
// Move request channel between the button front-end and the game controller.
// Carries the valid/ready move handshake, direction, move counter and new-game pulse.
// The master drives the request side; the slave drives move_ready.
interface move_input_ctrl_if;
  logic        move_valid;
  logic        move_ready;
  logic [1:0]  dir;
  logic        new_game;
  logic [15:0] move_count;

  modport master (
    output move_valid,
    output dir,
    output new_game,
    output move_count,
    input  move_ready
  );

  modport slave (
    input  move_valid,
    input  dir,
    input  new_game,
    input  move_count,
    output move_ready
  );
endinterface

// File: rtl/move_input_ctrl.sv
// Button front-end: sync + debounce five buttons, one move request per press, new-game pulse.
// Latency: raw press to move_valid is DEBOUNCE_CYCLES+3 edges; new_game follows the same path.
// Backpressure: a pending move waits in PEND for move_ready indefinitely; later presses are dropped.
module move_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_up,
  input  logic                btn_down,
  input  logic                btn_left,
  input  logic                btn_right,
  input  logic                btn_new,
  move_input_ctrl_if.master   mv
);

  // Bit positions: 0 up, 1 down, 2 left, 3 right, 4 new-game.
  localparam int NB = 5;
  localparam int NEW_IDX = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PEND     = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  logic [NB-1:0]    raw;
  logic [NB-1:0]    sync1_q, sync2_q;
  logic [NB-1:0]    db_q, db_d, db_dly_q;
  logic [CNT_W-1:0] cnt_q [NB];
  logic [CNT_W-1:0] cnt_d [NB];
  logic [NB-1:0]    press;
  logic             new_evt;
  logic             dir_evt;
  logic [1:0]       dir_sel;

  state_t           state_q, state_d;
  logic [1:0]       dir_q, dir_d;
  logic [15:0]      count_q, count_d;
  logic             new_game_q;
  logic             move_valid;

  assign raw = {btn_new, btn_right, btn_left, btn_down, btn_up};

  // Two-flop synchroniser for every raw button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count consecutive disagreeing cycles, accept the new level on the last count.
  always_comb begin
    for (int i = 0; i < NB; i++) begin
      db_d[i]  = db_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          db_d[i]  = sync2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounced state, its one-cycle delayed copy (for edge detect) and the counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_q     <= '0;
      db_dly_q <= '0;
      for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
    end else begin
      db_q     <= db_d;
      db_dly_q <= db_q;
      for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Press event is the 0->1 edge of the debounced level; releases produce nothing.
  always_comb begin
    press   = db_q & ~db_dly_q;
    new_evt = press[NEW_IDX];
    dir_evt = |press[3:0];
    if (press[0])      dir_sel = 2'd0;
    else if (press[1]) dir_sel = 2'd1;
    else if (press[2]) dir_sel = 2'd2;
    else               dir_sel = 2'd3;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: new-game overrides everything and parks in WAIT_REL.
  always_comb begin
    state_d = state_q;
    if (new_evt) begin
      state_d = WAIT_REL;
    end else begin
      case (state_q)
        IDLE:     if (dir_evt) state_d = PEND;
        PEND:     if (mv.move_ready) state_d = WAIT_REL;
        WAIT_REL: if (db_q[3:0] == 4'b0000) state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: a request is pending exactly while in PEND.
  always_comb begin
    move_valid = (state_q == PEND);
  end

  // Direction latch and accepted-move counter next values.
  always_comb begin
    dir_d   = dir_q;
    count_d = count_q;
    if (state_q == IDLE && dir_evt && !new_evt) dir_d = dir_sel;
    if (new_evt)                                count_d = 16'd0;
    else if (state_q == PEND && mv.move_ready)  count_d = count_q + 16'd1;
  end

  // Direction, counter and registered new-game pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q      <= 2'd0;
      count_q    <= 16'd0;
      new_game_q <= 1'b0;
    end else begin
      dir_q      <= dir_d;
      count_q    <= count_d;
      new_game_q <= new_evt;
    end
  end

  assign mv.move_valid = move_valid;
  assign mv.dir        = dir_q;
  assign mv.new_game   = new_game_q;
  assign mv.move_count = count_q;

endmodule
